// File: rtl/mem_map_pkg.sv
// Address map, I/O register offsets and region decode shared by the memory responder.
package mem_map_pkg;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hF000;

    localparam logic [15:0] IO_OUT  = 16'h0000;
    localparam logic [15:0] IO_CNT  = 16'h0002;
    localparam logic [15:0] IO_STAT = 16'h0004;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_UNMAPPED
    } region_t;

    // The I/O window takes priority; RAM is the low 2^addr_w words below it.
    function automatic region_t decode_region(input logic [15:0] addr,
                                              input logic [15:0] io_base,
                                              input int unsigned addr_w);
        if (addr >= io_base) begin
            return REG_IO;
        end
        if (32'({17'b0, addr[15:1]}) < (32'd1 << addr_w)) begin
            return REG_RAM;
        end
        return REG_UNMAPPED;
    endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port 16-bit word RAM, synchronous read with one cycle latency, read-before-write.
module sync_ram #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem_q [2**ADDR_W];

    // Contents are deliberately not reset; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM, fixed-latency read pipeline and a small I/O window
// (OUT register, free-running cycle counter, sticky misalignment status).
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [15:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_mem_addr,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [15:0] i_mem_wrdata,
    output logic [15:0] o_mem_rddata,
    output logic        o_mem_rdvalid,
    output logic [15:0] o_io_out,
    output logic        o_err
);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("mem_responder: RD_LATENCY must be in 1..4");
    end
    if (ADDR_W < 1 || ADDR_W > 15) begin : g_bad_addr_w
        $error("mem_responder: ADDR_W must be in 1..15");
    end

    region_t     region;
    logic        is_ram;
    logic        is_io;
    logic [15:0] io_word;
    logic [15:0] io_rdata;
    logic        ram_re;
    logic        ram_we;
    logic        out_we;
    logic        cnt_clr;
    logic [15:0] ram_rdata;

    logic [15:0] out_q;
    logic [15:0] cnt_q;
    logic        err_q;

    // First pipeline stage, aligned with the RAM's registered read data.
    logic        s1_valid_q;
    logic        s1_ram_q;
    logic [15:0] s1_io_data_q;

    logic [RD_LATENCY-1:0]       tap_vld;
    logic [RD_LATENCY-1:0][15:0] tap_dat;
    logic [RD_LATENCY-1:0]       dly_vld_q;
    logic [RD_LATENCY-1:0][15:0] dly_dat_q;
    logic [15:0]                 rddata_q;

    always_comb begin
        region  = decode_region(i_mem_addr, IO_BASE, ADDR_W);
        is_ram  = (region == REG_RAM);
        is_io   = (region == REG_IO);
        io_word = (i_mem_addr - IO_BASE) & 16'hFFFE;
        ram_re  = i_mem_rd & is_ram;
        ram_we  = i_mem_wr & is_ram;
        out_we  = i_mem_wr & is_io & (io_word == IO_OUT);
        cnt_clr = i_mem_wr & is_io & (io_word == IO_CNT);
    end

    always_comb begin
        io_rdata = '0;
        if (is_io) begin
            case (io_word)
                IO_OUT:  io_rdata = out_q;
                IO_CNT:  io_rdata = cnt_q;
                IO_STAT: io_rdata = {15'b0, err_q};
                default: io_rdata = '0;
            endcase
        end
    end

    sync_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (i_mem_addr[ADDR_W:1]),
        .wdata (i_mem_wrdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_ram_q     <= 1'b0;
            s1_io_data_q <= '0;
        end else begin
            if (out_we) begin
                out_q <= i_mem_wrdata;
            end
            cnt_q <= cnt_clr ? 16'h0000 : cnt_q + 16'd1;
            if ((i_mem_rd | i_mem_wr) & i_mem_addr[0]) begin
                err_q <= 1'b1;
            end
            s1_valid_q   <= i_mem_rd;
            s1_ram_q     <= is_ram;
            s1_io_data_q <= io_rdata;
        end
    end

    // Tap 0 is the first-stage mux; higher taps are the extra RD_LATENCY-1 delay stages.
    always_comb begin
        tap_vld    = dly_vld_q;
        tap_dat    = dly_dat_q;
        tap_vld[0] = s1_valid_q;
        tap_dat[0] = s1_ram_q ? ram_rdata : s1_io_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_vld_q <= '0;
            dly_dat_q <= '0;
            rddata_q  <= '0;
        end else begin
            dly_vld_q <= tap_vld << 1;
            dly_dat_q <= tap_dat << 16;
            if (tap_vld[RD_LATENCY-1]) begin
                rddata_q <= tap_dat[RD_LATENCY-1];
            end
        end
    end

    always_comb begin
        o_mem_rdvalid = tap_vld[RD_LATENCY-1];
        o_mem_rddata  = o_mem_rdvalid ? tap_dat[RD_LATENCY-1] : rddata_q;
        o_io_out      = out_q;
        o_err         = err_q;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU data/instruction memory interface. It answers byte-addressed 16-bit read and write requests from the processor core.
- Contains a word RAM, a fixed-latency read pipeline, and a small memory-mapped I/O window: an output register, a free-running cycle counter and a status register.
- Sits between the processor core and board I/O. It has no stall path, so latency is fixed by parameter and the core schedules around it.

Parameters:
- ADDR_W, 12, RAM word-address width (2^ADDR_W 16-bit words, byte range 0 to 2^(ADDR_W+1)-1).
- RD_LATENCY, 1, cycles from request sample edge to data valid. Legal range 1..4; elaboration error otherwise.
- IO_BASE, 16'hF000, first byte address of the I/O window, which runs IO_BASE..16'hFFFF.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low; clears all state immediately while low.
- i_mem_addr, in, 16, byte address from core.
- i_mem_rd, in, 1, read request; sampled each rising edge.
- i_mem_wr, in, 1, write request; sampled each rising edge.
- i_mem_wrdata, in, 16, write data.
- o_mem_rddata, out, 16, read data; holds its last value between reads.
- o_mem_rdvalid, out, 1, one-cycle pulse, aligned with each returned read.
- o_io_out, out, 16, contents of the OUT register.
- o_err, out, 1, sticky misaligned-access flag.

Behaviour:
- Reset (asynchronous, reset=0):
  - o_mem_rddata=0, o_mem_rdvalid=0, o_io_out=0, counter=0, o_err=0.
  - Read pipeline flushed; in-flight reads are discarded and never pulse rdvalid.
  - RAM contents are not reset.
- Address decode:
  - addr >= IO_BASE: I/O window.
  - else addr[15:1] < 2^ADDR_W: RAM, word index addr[ADDR_W:1].
  - else unmapped: reads return 16'h0000 with a normal rdvalid pulse; writes are dropped.
- Alignment:
  - addr[0] is ignored for addressing.
  - Any rd or wr with addr[0]=1 sets o_err at that edge. o_err stays set until reset.
- I/O registers (byte offsets from IO_BASE):
  - +0 OUT: R/W; drives o_io_out one cycle after the write edge.
  - +2 CNT: free-running 16-bit counter, +1 every cycle, wraps FFFF->0000. A read returns the value held before the sample edge's increment. A write clears it so the next cycle's value is 0; write data is ignored.
  - +4 STATUS: read-only, {15'b0, o_err}; writes ignored.
  - All other offsets: read 0, writes ignored.
- Reads:
  - A request sampled at edge k yields rddata and rdvalid=1 during the cycle after edge k+RD_LATENCY-1.
  - The pipeline is fully pipelined, so back-to-back reads on every cycle return in order, one per cycle.
- Writes take effect at the sample edge. A read one cycle later returns the new data.
- Same-cycle rd and wr to the same address: the write is performed and the read returns the old data (read-before-write).
- Reset asserted mid-stream: outputs clear at once. After release, the first sampled request behaves as if from idle.

Decomposition:
- Package mem_map_pkg holds:
  - IO_BASE default.
  - Offsets IO_OUT=0, IO_CNT=2, IO_STAT=4.
  - typedef enum region_t {REG_RAM, REG_IO, REG_UNMAPPED}.
- Sub-module sync_ram:
  - Single-port, synchronous-read, read-before-write RAM; parameter ADDR_W; 1-cycle latency.
  - mem_responder adds RD_LATENCY-1 delay stages on the data/valid mux output.

Test Plan:
- Reset then read 16'h0000 and 16'hF002 (RD_LATENCY=1) -> rdvalid pulses one cycle after each sample; RAM data is don't-care; CNT returns a small count since reset; o_err=0.
- Write 16'hBEEF to 16'h0010, read 16'h0010 the next cycle -> rddata=16'hBEEF. Same-cycle wr 16'h1234 + rd at 16'h0010 -> returns 16'hBEEF; a following read returns 16'h1234.
- RD_LATENCY=3: reads of 16'h0000, 16'h0002 and 16'h0004 on consecutive cycles (preloaded 1, 2, 3) -> rdvalid high for 3 consecutive cycles starting 3 cycles after the first sample, data 1, 2, 3 in order.
- Write 16'h00A5 to IO_BASE+0 -> o_io_out=16'h00A5 the next cycle. Write to IO_BASE+2, then read it the next cycle -> returns 0. Let CNT pass 16'hFFFF -> wraps to 0.
- Read 16'h0003 -> o_err=1 and stays set; read IO_BASE+4 -> 16'h0001. Read 16'h3000 with ADDR_W=12 -> 16'h0000 with a normal rdvalid pulse; a write there leaves RAM unchanged.
- Issue a read, assert reset before the data returns -> no rdvalid pulse, all outputs 0. After release, a read of 16'h0010 returns the pre-reset RAM value.
